// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fixed instruction encodings and the fetch FSM state type.
package mips_pkg;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: PC register, instruction memory, hazard/redirect inputs and IF/ID outputs.
// FETCH_STEP_EN adds the debug single-step controls.
interface fetch_stage_if #(
    parameter int IMEM_AW = 10,
    parameter int CNT_W   = 32
);
    logic [31:0]        pc_q;
    logic [31:0]        pc_d;
    logic               pc_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               stall;
    logic               flush;
    logic               branch_taken;
    logic [31:0]        branch_target;
    logic               jump;
    logic [31:0]        jump_target;
    logic [31:0]        if_id_instr;
    logic [31:0]        if_id_pc4;
    logic               if_id_valid;
    logic               halted;
    logic [CNT_W-1:0]   fetch_count;
`ifdef FETCH_STEP_EN
    logic               step_mode;
    logic               step;
`endif

    // master = the fetch stage, slave = the surrounding pipeline
    modport master (
        input  pc_q, imem_rdata, stall, flush, branch_taken, branch_target, jump, jump_target,
`ifdef FETCH_STEP_EN
        input  step_mode, step,
`endif
        output pc_d, pc_en, imem_addr, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_count
    );

    modport slave (
        output pc_q, imem_rdata, stall, flush, branch_taken, branch_target, jump, jump_target,
`ifdef FETCH_STEP_EN
        output step_mode, step,
`endif
        input  pc_d, pc_en, imem_addr, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_count
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: squash beats hold beats bubble beats load.
module if_id_reg #(
    parameter logic [31:0] NOP = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        squash_i,
    input  logic        hold_i,
    input  logic        bubble_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);
    logic [31:0] instr_q, pc4_q;
    logic        valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= NOP;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else if (squash_i) begin
            instr_q <= NOP;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else if (hold_i) begin
            instr_q <= instr_q;
        end else if (bubble_i) begin
            // pc4 is left as-is: it is meaningless while valid is low
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: next-PC, IF/ID capture, HALT detection and fetch counter.
// FETCH_STEP_EN enables debug single-step gating of fetch.
module fetch_stage #(
    parameter int          IMEM_AW     = 10,
    parameter logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
    parameter int          CNT_W       = 32
) (
    input logic               clk,
    input logic               reset,
    fetch_stage_if.master     fb
);
    import mips_pkg::*;

    fetch_state_t     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pc4;
    logic             redir, is_halt, go;
    logic             squash, hold, bubble, load, pc_en;

    assign redir   = fb.branch_taken | fb.jump;
    assign is_halt = (fb.imem_rdata == HALT_OPCODE);
    assign pc4     = fb.pc_q + 32'd4;

`ifdef FETCH_STEP_EN
    assign go = ~fb.step_mode | fb.step;
`else
    assign go = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    // Only a right-path load can halt; squashed HALT words never reach here as load
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && load && is_halt) state_d = HALT;
    end

    // A missing step pulse acts exactly like a stall while running
    always_comb begin
        squash = fb.flush | redir;
        hold   = ~squash & (fb.stall | (state_q == RUN & ~go));
        bubble = ~squash & ~hold & (state_q == HALT);
        load   = ~squash & ~hold & (state_q == RUN);
        pc_en  = redir | (state_q == RUN & ~fb.stall & go & ~is_halt);
    end

    assign count_d = count_q + CNT_W'(load);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign fb.pc_d        = fb.branch_taken ? fb.branch_target :
                            fb.jump         ? fb.jump_target   : pc4;
    assign fb.pc_en       = pc_en;
    assign fb.imem_addr   = fb.pc_q[IMEM_AW+1:2];
    assign fb.halted      = (state_q == HALT);
    assign fb.fetch_count = count_q;

    if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
        .clk      (clk),
        .reset    (reset),
        .squash_i (squash),
        .hold_i   (hold),
        .bubble_i (bubble),
        .instr_i  (fb.imem_rdata),
        .pc4_i    (pc4),
        .instr_o  (fb.if_id_instr),
        .pc4_o    (fb.if_id_pc4),
        .valid_o  (fb.if_id_valid)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random traffic against a behavioural model.
module tb_fetch_stage;
    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if #(.IMEM_AW(10), .CNT_W(32)) bus ();
    fetch_stage dut (.clk(clk), .reset(reset), .fb(bus));

    logic [31:0] imem [1024];
    int n_chk = 0;
    int n_fail = 0;

    // testbench-side PC register and stimulus
    logic [31:0] pc;
    bit st, fl, bt, jp, smode, sstep;
    logic [31:0] btgt, jtgt;

    // behavioural model of the registered outputs
    bit m_halt, m_valid;
    logic [31:0] m_instr, m_pc4, m_cnt;

    function automatic void model_reset();
        m_halt = 0; m_valid = 0; m_instr = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
    endfunction

    function automatic logic [31:0] exp_pc_d();
        if (bt) return btgt;
        if (jp) return jtgt;
        return pc + 32'd4;
    endfunction

    function automatic bit exp_pc_en();
        bit go = !smode || sstep;
        return bt || jp || (!m_halt && !st && go && imem[pc[11:2]] != HALT_W);
    endfunction

    task automatic apply();
        bus.pc_q = pc;
        bus.imem_rdata = imem[pc[11:2]];
        bus.stall = st;
        bus.flush = fl;
        bus.branch_taken = bt;
        bus.branch_target = btgt;
        bus.jump = jp;
        bus.jump_target = jtgt;
`ifdef FETCH_STEP_EN
        bus.step_mode = smode;
        bus.step = sstep;
`endif
        #1;
    endtask

    task automatic tick();
        logic [31:0] rd = imem[pc[11:2]];
        bit go = !smode || sstep;
        logic [31:0] npc = exp_pc_en() ? exp_pc_d() : pc;
        if (fl || bt || jp) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
        end else if (st || (!go && !m_halt)) begin
            m_valid = m_valid;
        end else if (m_halt) begin
            m_instr = 32'h0; m_valid = 0;
        end else begin
            m_instr = rd; m_pc4 = pc + 32'd4; m_valid = 1; m_cnt = m_cnt + 1;
            if (rd == HALT_W) m_halt = 1;
        end
        @(posedge clk);
        #1;
        pc = npc;
        apply();
    endtask

    task automatic quiet();
        st = 0; fl = 0; bt = 0; jp = 0; smode = 0; sstep = 0; btgt = 32'h0; jtgt = 32'h0;
    endtask

    task automatic test_reset();
        quiet();
        pc = 32'h0;
        model_reset();
        apply();
        #10;
        n_chk++;
        if ({bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid, bus.halted, bus.fetch_count} !== {32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h %h %b %b %0d, want 0 0 0 0 0", bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid, bus.halted, bus.fetch_count);
        end
        @(negedge clk);
        reset = 0;
        apply();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (bus.pc_d !== 32'(4 * (i + 1)) || bus.pc_en !== 1'b1 || bus.imem_addr !== pc[11:2]) begin
                n_fail++;
                $display("FAIL seq_pc_d[%0d]: got %h en=%b addr=%h, want %h en=1 addr=%h", i, bus.pc_d, bus.pc_en, bus.imem_addr, 4 * (i + 1), pc[11:2]);
            end
            tick();
            n_chk++;
            if (bus.if_id_valid !== 1'b1 || bus.if_id_instr !== imem[i] || bus.if_id_pc4 !== 32'(4 * (i + 1))) begin
                n_fail++;
                $display("FAIL seq_ifid[%0d]: got %h %h v=%b, want %h %h v=1", i, bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid, imem[i], 4 * (i + 1));
            end
        end
        n_chk++;
        if (bus.fetch_count !== 32'd3) begin
            n_fail++;
            $display("FAIL seq_count: got %0d, want 3", bus.fetch_count);
        end
    endtask

    task automatic test_stall();
        logic [31:0] pc4_saved, cnt_saved;
        imem[pc[11:2]] = 32'h2001_0005;
        pc4_saved = pc + 32'd4;
        apply();
        tick();
        cnt_saved = m_cnt;
        st = 1;
        apply();
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (bus.pc_en !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_pc_en[%0d]: got %b, want 0", i, bus.pc_en);
            end
            tick();
            n_chk++;
            if (bus.if_id_instr !== 32'h2001_0005 || bus.if_id_pc4 !== pc4_saved || bus.if_id_valid !== 1'b1 || bus.fetch_count !== cnt_saved) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %h %h v=%b cnt=%0d, want 20010005 %h v=1 cnt=%0d", i, bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid, bus.fetch_count, pc4_saved, cnt_saved);
            end
        end
    endtask

    task automatic test_branch_stall();
        st = 1; bt = 1; btgt = 32'h40;
        apply();
        n_chk++;
        if (bus.pc_d !== 32'h40 || bus.pc_en !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_pc: got %h en=%b, want 00000040 en=1", bus.pc_d, bus.pc_en);
        end
        tick();
        n_chk++;
        if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL branch_squash: got %h v=%b, want 0 v=0", bus.if_id_instr, bus.if_id_valid);
        end
        quiet();
        apply();
    endtask

    task automatic test_halt();
        pc = 32'h10;
        imem[4] = HALT_W;
        apply();
        n_chk++;
        if (bus.pc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_pc_en: got %b, want 0", bus.pc_en);
        end
        tick();
        n_chk++;
        if (bus.if_id_instr !== HALT_W || bus.if_id_valid !== 1'b1 || bus.halted !== 1'b1 || pc !== 32'h10) begin
            n_fail++;
            $display("FAIL halt_load: got %h v=%b halted=%b pc=%h, want ffffffff v=1 halted=1 pc=10", bus.if_id_instr, bus.if_id_valid, bus.halted, pc);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (bus.if_id_instr !== 32'h0 || bus.if_id_valid !== 1'b0 || bus.halted !== 1'b1 || bus.pc_en !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_bubble[%0d]: got %h v=%b halted=%b en=%b, want 0 v=0 halted=1 en=0", i, bus.if_id_instr, bus.if_id_valid, bus.halted, bus.pc_en);
            end
        end
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1;
        #1;
        n_chk++;
        if ({bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid, bus.halted, bus.fetch_count} !== {32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL async_reset: got %h %h %b %b %0d, want 0 0 0 0 0", bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid, bus.halted, bus.fetch_count);
        end
        model_reset();
        @(negedge clk);
        reset = 0;
        pc = 32'h0;
        apply();
        tick();
        n_chk++;
        if (bus.halted !== 1'b0 || bus.if_id_valid !== 1'b1 || bus.if_id_instr !== imem[0] || bus.fetch_count !== 32'd1) begin
            n_fail++;
            $display("FAIL reset_run: got halted=%b v=%b %h cnt=%0d, want halted=0 v=1 %h cnt=1", bus.halted, bus.if_id_valid, bus.if_id_instr, bus.fetch_count, imem[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 9) == 0);
            bt = ($urandom_range(0, 11) == 0);
            jp = ($urandom_range(0, 11) == 0);
            btgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFF);
            jtgt = $urandom & 32'h0000_0FFC;
`ifdef FETCH_STEP_EN
            smode = ($urandom_range(0, 3) == 0);
            sstep = $urandom_range(0, 1) == 1;
`endif
            imem[pc[11:2]] = ($urandom_range(0, 15) == 0) ? HALT_W : ($urandom & 32'h7FFF_FFFF);
            apply();
            n_chk++;
            if ({bus.pc_d, bus.pc_en, bus.imem_addr} !== {exp_pc_d(), exp_pc_en(), pc[11:2]}) begin
                n_fail++;
                $display("FAIL rand_comb[%0d]: got pc_d=%h en=%b addr=%h, want pc_d=%h en=%b addr=%h", i, bus.pc_d, bus.pc_en, bus.imem_addr, exp_pc_d(), exp_pc_en(), pc[11:2]);
            end
            tick();
            n_chk++;
            if ({bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid, bus.halted, bus.fetch_count} !== {m_instr, m_pc4, m_valid, m_halt, m_cnt}) begin
                n_fail++;
                $display("FAIL rand_ifid[%0d]: got %h %h v=%b h=%b cnt=%0d, want %h %h v=%b h=%b cnt=%0d", i, bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid, bus.halted, bus.fetch_count, m_instr, m_pc4, m_valid, m_halt, m_cnt);
            end
            if (m_halt && $urandom_range(0, 9) == 0) begin
                #2;
                reset = 1;
                #2;
                reset = 0;
                model_reset();
            end
        end
        quiet();
        apply();
    endtask

`ifdef FETCH_STEP_EN
    task automatic test_step();
        quiet();
        @(negedge clk);
        reset = 1;
        #2;
        reset = 0;
        model_reset();
        pc = 32'h0;
        for (int i = 0; i < 16; i++) imem[i] = $urandom & 32'h7FFF_FFFF;
        smode = 1;
        apply();
        for (int i = 0; i < 10; i++) begin
            sstep = (i == 2 || i == 6);
            apply();
            tick();
            n_chk++;
            if ({bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid, bus.fetch_count} !== {m_instr, m_pc4, m_valid, m_cnt}) begin
                n_fail++;
                $display("FAIL step_cycle[%0d]: got %h %h v=%b cnt=%0d, want %h %h v=%b cnt=%0d", i, bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid, bus.fetch_count, m_instr, m_pc4, m_valid, m_cnt);
            end
        end
        n_chk++;
        if (bus.fetch_count !== 32'd2 || pc !== 32'h8) begin
            n_fail++;
            $display("FAIL step_count: got cnt=%0d pc=%h, want cnt=2 pc=00000008", bus.fetch_count, pc);
        end
        quiet();
        apply();
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = $urandom & 32'h7FFF_FFFF;
        test_reset();
        test_sequential();
        test_stall();
        test_branch_stall();
        test_halt();
        test_async_reset();
        test_random();
`ifdef FETCH_STEP_EN
        test_step();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
